// File: rtl/y_demux2_stream_pkg.sv
// Shared constants for the registered 1-to-2 stream demultiplexer.
// Select encoding and default widths used by the top and its counters.
package y_demux2_stream_pkg;

  localparam int W_DEFAULT  = 2;
  localparam int CW_DEFAULT = 8;

  localparam logic SEL_Z0 = 1'b0;
  localparam logic SEL_Z1 = 1'b1;

endpackage

// File: rtl/y_wrap_counter.sv
// Free-running enable counter that wraps modulo 2^CW, cleared asynchronously.
module y_wrap_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/y_demux2_stream.sv
// Registered 1-to-2 stream demux: a single holding stage steers each accepted
// word to z0 or z1 by its select bit and counts completed transfers per output.
module y_demux2_stream
  import y_demux2_stream_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  a,
  input  logic          c,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  z0,
  output logic          z0_valid,
  input  logic          z0_ready,
  output logic [W-1:0]  z1,
  output logic          z1_valid,
  input  logic          z1_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  logic [W-1:0] data_reg;
  logic         sel_reg;
  logic         full_reg;
  logic         z0_fire;
  logic         z1_fire;
  logic         out_fire;
  logic         in_fire;

  // Outputs come from the holding stage only, so a/c/in_valid never reach them.
  assign z0_valid = full_reg & (sel_reg == SEL_Z0);
  assign z1_valid = full_reg & (sel_reg == SEL_Z1);
  assign z0       = data_reg & {W{z0_valid}};
  assign z1       = data_reg & {W{z1_valid}};

  assign z0_fire  = z0_valid & z0_ready;
  assign z1_fire  = z1_valid & z1_ready;
  assign out_fire = z0_fire | z1_fire;

  // Held low during reset so nothing is taken while the stage is being cleared.
  assign in_ready = rst_n & (~full_reg | out_fire);
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      sel_reg  <= SEL_Z0;
      full_reg <= 1'b0;
    end else if (in_fire) begin
      data_reg <= a;
      sel_reg  <= c;
      full_reg <= 1'b1;
    end else if (out_fire) begin
      full_reg <= 1'b0;
    end
  end

  y_wrap_counter #(.CW(CW)) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (z0_fire),
    .count (cnt0)
  );

  y_wrap_counter #(.CW(CW)) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (z1_fire),
    .count (cnt1)
  );

endmodule

// File: tb/tb_y_demux2_stream.sv
// Bench for y_demux2_stream: directed scenarios plus random traffic, all
// checked against a queue-based model of the one-entry stage and two counters.
module tb_y_demux2_stream;

  localparam int W  = 2;
  localparam int CW = 8;
  localparam int CMOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  a = '0;
  logic          c = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  z0;
  logic          z0_valid;
  logic          z0_ready = 1'b1;
  logic [W-1:0]  z1;
  logic          z1_valid;
  logic          z1_ready = 1'b1;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int total = 0;
  int bad = 0;

  // Model: words in flight as {sel, data}; at most one entry at any time.
  logic [W:0] held_q[$];
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  always #5 clk = ~clk;

  y_demux2_stream #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .c        (c),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .z0       (z0),
    .z0_valid (z0_valid),
    .z0_ready (z0_ready),
    .z1       (z1),
    .z1_valid (z1_valid),
    .z1_ready (z1_ready),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic model_out_fire();
    if (held_q.size() == 0) return 1'b0;
    return held_q[0][W] ? z1_ready : z0_ready;
  endfunction

  task automatic compare_outputs();
    logic          f;
    logic          s;
    logic [W-1:0]  d;
    f = (held_q.size() > 0);
    s = f ? held_q[0][W] : 1'b0;
    d = f ? held_q[0][W-1:0] : '0;
    check("z0_valid", 32'(z0_valid), 32'(f && !s));
    check("z1_valid", 32'(z1_valid), 32'(f && s));
    check("z0", 32'(z0), (f && !s) ? 32'(d) : 0);
    check("z1", 32'(z1), (f && s) ? 32'(d) : 0);
    check("in_ready", 32'(in_ready), 32'(rst_n && (!f || model_out_fire())));
    check("cnt0", 32'(cnt0), exp_cnt0);
    check("cnt1", 32'(cnt1), exp_cnt1);
  endtask

  // Advance one clock: decide handshakes from the values driven before the
  // edge, update the model at the edge, then compare just after it.
  task automatic step();
    logic of;
    logic inf;
    logic sel;
    of  = rst_n && model_out_fire();
    inf = rst_n && in_valid && (held_q.size() == 0 || of);
    sel = (held_q.size() > 0) ? held_q[0][W] : 1'b0;
    @(posedge clk);
    if (of) begin
      void'(held_q.pop_front());
      if (sel) exp_cnt1 = (exp_cnt1 + 1) % CMOD;
      else     exp_cnt0 = (exp_cnt0 + 1) % CMOD;
    end
    if (inf) held_q.push_back({c, a});
    #1;
    compare_outputs();
  endtask

  task automatic model_reset();
    held_q.delete();
    exp_cnt0 = 0;
    exp_cnt1 = 0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 1);
    step();
  endtask

  initial begin
    // Reset then idle
    #1;
    reset_pulse();
    check("idle_z0_valid", 32'(z0_valid), 0);
    check("idle_z1_valid", 32'(z1_valid), 0);
    check("idle_cnt0", 32'(cnt0), 0);
    step();

    // Exhaustive sweep over a and c at full rate
    z0_ready = 1'b1;
    z1_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = W'(i / 2);
      c = 1'(i % 2);
      step();
      if (i % 2 == 0) begin
        check("sweep_z0", 32'(z0), i / 2);
        check("sweep_z1_valid", 32'(z1_valid), 0);
      end else begin
        check("sweep_z1", 32'(z1), i / 2);
        check("sweep_z0_valid", 32'(z0_valid), 0);
      end
    end
    in_valid = 1'b0;
    step();
    check("sweep_cnt0", 32'(cnt0), 4);
    check("sweep_cnt1", 32'(cnt1), 4);

    // Backpressure on z1 while a z0 word waits at the input
    a = 2'b10; c = 1'b1; z1_ready = 1'b0; z0_ready = 1'b1; in_valid = 1'b1;
    step();
    a = 2'b01; c = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_z1", 32'(z1), 2);
      check("bp_z1_valid", 32'(z1_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_z0_valid", 32'(z0_valid), 0);
      step();
    end
    begin
      int base1;
      base1 = exp_cnt1;
      z1_ready = 1'b1;
      step();
      check("bp_z0", 32'(z0), 1);
      check("bp_z0_valid_after", 32'(z0_valid), 1);
      check("bp_cnt1_inc", 32'(cnt1), (base1 + 1) % CMOD);
    end
    in_valid = 1'b0;
    step();

    // Alternating select at full rate
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c = 1'(i % 2);
      a = W'(3 - i);
      check("alt_in_ready", 32'(in_ready), 1);
      step();
      if (i % 2 == 0) check("alt_z0", 32'(z0), 3 - i);
      else            check("alt_z1", 32'(z1), 3 - i);
    end
    in_valid = 1'b0;
    step();

    // Reset mid-operation with a word held for a stalled z0
    a = 2'b11; c = 1'b0; z0_ready = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_z0_valid_held", 32'(z0_valid), 1);
    check("mid_z0_held", 32'(z0), 3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_z0_valid_async", 32'(z0_valid), 0);
    check("mid_z0_async", 32'(z0), 0);
    check("mid_cnt0_clear", 32'(cnt0), 0);
    check("mid_cnt1_clear", 32'(cnt1), 0);
    check("mid_in_ready", 32'(in_ready), 0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", 32'(in_ready), 1);
    step();
    check("mid_empty", 32'(z0_valid | z1_valid), 0);
    z0_ready = 1'b1;

    // Counter wrap: 256 z0 transfers from a clean reset
    reset_pulse();
    in_valid = 1'b1; c = 1'b0; z0_ready = 1'b1; z1_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      a = W'($urandom_range(3, 0));
      step();
    end
    in_valid = 1'b0;
    step();
    check("wrap_cnt0_255", 32'(cnt0), 255);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("wrap_cnt0_0", 32'(cnt0), 0);
    check("wrap_cnt1_0", 32'(cnt1), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(3, 0) != 0);
      a        = W'($urandom_range(3, 0));
      c        = 1'($urandom_range(1, 0));
      z0_ready = ($urandom_range(3, 0) != 0);
      z1_ready = ($urandom_range(3, 0) != 0);
      step();
    end
    in_valid = 1'b0;
    z0_ready = 1'b1;
    z1_ready = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
